grf: RTL

GRF -- requirements
Module: grf

---
 rtl/grf_pkg.sv | 25 ++
 rtl/grf_if.sv | 20 ++
 rtl/grf.sv | 75 +++++++
 3 files changed

// File: rtl/grf_pkg.sv
// Shared definitions for the general register file: instruction field
// ranges, special register indices and trace formatting width.
`default_nettype none

package grf_pkg;

   localparam int RS_HI = 25;
   localparam int RS_LO = 21;
   localparam int RT_HI = 20;
   localparam int RT_LO = 16;
   localparam int RD_HI = 15;
   localparam int RD_LO = 11;

   localparam logic [4:0] ZERO_REG = 5'd0;
   localparam logic [4:0] RA_REG   = 5'd31;

   localparam int TRACE_HEX_W = 8;
   localparam int NUM_REGS    = 32;

   typedef logic [31:0] word_t;
   typedef logic [4:0]  reg_idx_t;

endpackage

`default_nettype wire

// File: rtl/grf_if.sv
// Write-back / operand-read bundle between the pipeline and the register file.
`default_nettype none

interface grf_if;
   import grf_pkg::*;

   logic     we;
   reg_idx_t WA;
   word_t    WD;
   word_t    PC_W;
   reg_idx_t RA1;
   reg_idx_t RA2;
   word_t    RD1;
   word_t    RD2;

   modport master (output we, WA, WD, PC_W, RA1, RA2, input RD1, RD2);
   modport slave  (input we, WA, WD, PC_W, RA1, RA2, output RD1, RD2);
endinterface

`default_nettype wire

// File: rtl/grf.sv
// 32x32 register file, $0 hardwired to zero, write-then-read bypass per port.
// Define GRF_TRACE_EN to print one simulation line per committed write.
`default_nettype none

module grf
   import grf_pkg::*;
(
   input  wire logic     clk,
   input  wire logic     reset,
   input  wire logic     we,
   input  wire reg_idx_t WA,
   input  wire word_t    WD,
   input  wire word_t    PC_W,
   input  wire reg_idx_t RA1,
   input  wire reg_idx_t RA2,
   output      word_t    RD1,
   output      word_t    RD2
);

   word_t regs_q [NUM_REGS];
   word_t regs_d [NUM_REGS];
   logic  wr_commit;

   assign wr_commit = we && (WA != ZERO_REG);

   always_comb begin
      for (int i = 0; i < NUM_REGS; i++) begin
         regs_d[i] = regs_q[i];
      end
      if (wr_commit) begin
         regs_d[WA] = WD;
      end
   end

   // Async clear also aborts any write pending in the current cycle.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            regs_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NUM_REGS; i++) begin
            regs_q[i] <= regs_d[i];
         end
      end
   end

   function automatic word_t bypass_read(input reg_idx_t ra, input word_t stored,
                                         input logic wen, input reg_idx_t wa,
                                         input word_t wd);
      if (ra == ZERO_REG)
         return '0;
      else if (wen && (wa != ZERO_REG) && (wa == ra))
         return wd;
      else
         return stored;
   endfunction

   assign RD1 = bypass_read(RA1, regs_q[RA1], we, WA, WD);
   assign RD2 = bypass_read(RA2, regs_q[RA2], we, WA, WD);

`ifdef GRF_TRACE_EN
   always @(posedge clk) begin
      if (reset && wr_commit) begin
         $display("@%h: $%d <= %h", PC_W, WA, WD);
      end
   end
`else
   logic unused_pc;
   assign unused_pc = ^PC_W;
`endif

endmodule

`default_nettype wire
